// File: rtl/dmem_io_unit.sv
// dmem_io_unit: word RAM plus memory-mapped display latch, debounced
// switches and a sticky switch-change flag on the PMIPSL0 data port.

module dmem_io_switch #(
    parameter int DEBOUNCE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic fire
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t state;
    logic s1;
    logic s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + CW'(1);

    // The candidate is always ~db while counting, so it needs no register.
    always_comb begin
        fire = 1'b0;
        unique case (state)
            IDLE:    fire = (s2 != db) && (DEBOUNCE == 1);
            COUNT:   fire = (s2 != db) && (cnt_inc == LAST);
            default: fire = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            db    <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
        end else begin
            s1 <= raw;
            s2 <= s1;
            unique case (state)
                IDLE: begin
                    if (s2 != db) begin
                        if (fire) begin
                            db <= s2;
                        end else begin
                            cnt   <= CW'(1);
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (s2 == db) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (fire) begin
                        db    <= s2;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

module dmem_io_unit #(
    parameter int             DEPTH      = 128,
    parameter int             DEBOUNCE   = 4,
    parameter logic [6:0]     DISP_RESET = 7'b1111111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        memwrite,
    input  logic        memread,
    input  logic        sw0,
    input  logic        sw1,
    output logic [15:0] rdata,
    output logic [6:0]  display,
    output logic        sw_changed
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic is_io;
    logic is_ram;
    logic sel_disp;
    logic sel_sw0;
    logic sel_sw1;
    logic sel_stat;
    logic sw0_db;
    logic sw1_db;
    logic fire0;
    logic fire1;
    logic chg;

    assign idx      = addr[AW:1];
    assign is_io    = (addr[15:4] == 12'hFFF);
    assign is_ram   = !is_io;
    assign sel_disp = (addr == 16'hFFF0);
    assign sel_sw0  = (addr == 16'hFFF2);
    assign sel_sw1  = (addr == 16'hFFF4);
    assign sel_stat = (addr == 16'hFFF6);

    dmem_io_switch #(
        .DEBOUNCE(DEBOUNCE)
    ) u_sw0 (
        .clock(clock),
        .reset(reset),
        .raw  (sw0),
        .db   (sw0_db),
        .fire (fire0)
    );

    dmem_io_switch #(
        .DEBOUNCE(DEBOUNCE)
    ) u_sw1 (
        .clock(clock),
        .reset(reset),
        .raw  (sw1),
        .db   (sw1_db),
        .fire (fire1)
    );

    // RAM has no reset so a write racing reset assertion still lands.
    always_ff @(posedge clock) begin
        if (memwrite && is_ram) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            display <= DISP_RESET;
        end else if (memwrite && sel_disp) begin
            display <= wdata[6:0];
        end
    end

    // A debounced update in the same cycle as a status read keeps chg set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chg <= 1'b0;
        end else if (fire0 || fire1) begin
            chg <= 1'b1;
        end else if (memread && sel_stat) begin
            chg <= 1'b0;
        end
    end

    assign sw_changed = chg;

    always_comb begin
        rdata = 16'h0000;
        if (memread) begin
            unique case (1'b1)
                is_ram:   rdata = mem[idx];
                sel_disp: rdata = {9'b0, display};
                sel_sw0:  rdata = {15'b0, sw0_db};
                sel_sw1:  rdata = {15'b0, sw1_db};
                sel_stat: rdata = {15'b0, chg};
                default:  rdata = 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_io_unit.sv
// Scoreboard bench for dmem_io_unit: stimulus queues expectations,
// a negedge monitor pops and compares them.

module tb_dmem_io_unit;
    logic        clock;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        memwrite;
    logic        memread;
    logic        sw0;
    logic        sw1;
    logic [15:0] rdata;
    logic [6:0]  display;
    logic        sw_changed;

    typedef struct {
        string       name;
        logic [2:0]  mask;
        logic [15:0] rd;
        logic [6:0]  disp;
        logic        chg;
    } exp_t;

    exp_t q[$];
    logic sample;
    int checks;
    int errors;

    dmem_io_unit #(
        .DEPTH     (128),
        .DEBOUNCE  (4),
        .DISP_RESET(7'b1111111)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .memwrite  (memwrite),
        .memread   (memread),
        .sw0       (sw0),
        .sw1       (sw1),
        .rdata     (rdata),
        .display   (display),
        .sw_changed(sw_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sample) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: queue empty, got nothing required entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.mask[0]) begin
                    checks++;
                    if (rdata !== e.rd) begin
                        errors++;
                        $display("FAIL %s rdata: got %h required %h",
                                 e.name, rdata, e.rd);
                    end
                end
                if (e.mask[1]) begin
                    checks++;
                    if (display !== e.disp) begin
                        errors++;
                        $display("FAIL %s display: got %h required %h",
                                 e.name, display, e.disp);
                    end
                end
                if (e.mask[2]) begin
                    checks++;
                    if (sw_changed !== e.chg) begin
                        errors++;
                        $display("FAIL %s sw_changed: got %b required %b",
                                 e.name, sw_changed, e.chg);
                    end
                end
            end
        end
    end

    // One bus cycle; starts and ends 1ns after a rising edge.
    task automatic op(input string name, input logic rd_en,
                      input logic wr_en, input logic [15:0] a,
                      input logic [15:0] d, input logic [2:0] mask,
                      input logic [15:0] erd, input logic [6:0] edisp,
                      input logic echg);
        exp_t e;
        addr     = a;
        wdata    = d;
        memread  = rd_en;
        memwrite = wr_en;
        if (mask != 3'b000) begin
            e.name = name;
            e.mask = mask;
            e.rd   = erd;
            e.disp = edisp;
            e.chg  = echg;
            q.push_back(e);
            sample = 1'b1;
        end
        @(posedge clock);
        #1;
        sample   = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            op("idle", 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000,
               16'h0, 7'h0, 1'b0);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        op("wr", 1'b0, 1'b1, a, d, 3'b000, 16'h0, 7'h0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [15:0] a,
                      input logic [15:0] erd);
        op(name, 1'b1, 1'b0, a, 16'h0, 3'b001, erd, 7'h0, 1'b0);
    endtask

    task automatic rdc(input string name, input logic [15:0] a,
                       input logic [15:0] erd, input logic echg);
        op(name, 1'b1, 1'b0, a, 16'h0, 3'b101, erd, 7'h0, echg);
    endtask

    task automatic outs(input string name, input logic [6:0] edisp,
                        input logic echg);
        op(name, 1'b0, 1'b0, 16'h0010, 16'h0, 3'b111, 16'h0000,
           edisp, echg);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        sample   = 1'b0;
        reset    = 1'b0;
        addr     = 16'h0;
        wdata    = 16'h0;
        memwrite = 1'b0;
        memread  = 1'b0;
        sw0      = 1'b0;
        sw1      = 1'b0;
        @(posedge clock);
        #1;
        outs("in_reset", 7'h7F, 1'b0);
        reset = 1'b1;
        idle(1);

        outs("after_reset", 7'h7F, 1'b0);
        rd("rst_sw0", 16'hFFF2, 16'h0000);
        rd("rst_sw1", 16'hFFF4, 16'h0000);
        rd("rst_stat", 16'hFFF6, 16'h0000);
        rd("rst_resv", 16'hFFFA, 16'h0000);

        wr(16'h0010, 16'hBEEF);
        wr(16'h0012, 16'h1234);
        rd("ram_0010", 16'h0010, 16'hBEEF);
        rd("ram_0012", 16'h0012, 16'h1234);
        rd("ram_alias", 16'h0110, 16'hBEEF);
        rd("ram_odd", 16'h0013, 16'h1234);
        outs("ram_noread", 7'h7F, 1'b0);
        op("ram_rw", 1'b1, 1'b1, 16'h0010, 16'h5555, 3'b001,
           16'hBEEF, 7'h0, 1'b0);
        rd("ram_after_rw", 16'h0010, 16'h5555);
        wr(16'h00F2, 16'hAAAA);
        wr(16'hFFF2, 16'h1111);
        rd("io_no_ram", 16'h00F2, 16'hAAAA);

        wr(16'hFFF0, 16'hFF40);
        outs("disp_latch", 7'h40, 1'b0);
        rd("disp_read", 16'hFFF0, 16'h0040);

        sw0 = 1'b1;
        idle(5);
        rdc("sw0_early", 16'hFFF2, 16'h0000, 1'b0);
        rdc("sw0_edge", 16'hFFF2, 16'h0001, 1'b1);
        rd("stat_set", 16'hFFF6, 16'h0001);
        rdc("stat_clr", 16'hFFF6, 16'h0000, 1'b0);

        sw1 = 1'b1;
        idle(3);
        sw1 = 1'b0;
        idle(8);
        rdc("glitch_rej", 16'hFFF4, 16'h0000, 1'b0);

        sw1 = 1'b1;
        idle(5);
        sw1 = 1'b0;
        idle(1);
        rdc("pulse5_acc", 16'hFFF4, 16'h0001, 1'b1);
        idle(10);
        rd("pulse5_fall", 16'hFFF4, 16'h0000);
        rd("stat_set2", 16'hFFF6, 16'h0001);
        rdc("stat_clr2", 16'hFFF6, 16'h0000, 1'b0);

        sw0 = 1'b0;
        idle(5);
        rd("race_read", 16'hFFF6, 16'h0000);
        rdc("race_keep", 16'hFFF2, 16'h0000, 1'b1);

        sw0 = 1'b1;
        idle(4);
        reset = 1'b0;
        #1;
        outs("async_clr", 7'h7F, 1'b0);
        reset = 1'b1;
        idle(5);
        rdc("post_rst_early", 16'hFFF2, 16'h0000, 1'b0);
        rdc("post_rst_edge", 16'hFFF2, 16'h0001, 1'b1);
        outs("post_rst_disp", 7'h7F, 1'b1);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end
endmodule
